// File: rtl/muldiv_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_if : launch/result bundle between the decoder and muldiv_unit
// Revision : 1.0
// ----------------------------------------------------------------------------
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op_sel, src_a, src_b, flush,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op_sel, src_a, src_b, flush,
    output busy, done, hi, lo, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_unit : iterative signed/unsigned multiply and divide into HI/LO
// Revision : 1.0
// ----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               sign_q;
  logic               sign_r;
  logic               zero_div;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   raw_a;
  logic [2*WIDTH-1:0] acc;
  logic               busy_r;
  logic               done_r;
  logic               dbz_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               in_signed;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_geq;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_comb begin
    in_signed = ~bus.op_sel[0];
    abs_a     = (in_signed && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
    abs_b     = (in_signed && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

    // Shift-add: upper half accumulates, multiplier drains out of the low half.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: remainder in upper half, dividend/quotient in lower half.
    // Since remainder < divisor, the top bit of the difference is a clean borrow.
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_geq   = ~div_diff[WIDTH];
    div_next  = {(div_geq ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc[WIDTH-2:0], div_geq};

    prod_fix = sign_q ? -acc : acc;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (zero_div) begin
        res_hi = raw_a;
        res_lo = '1;
      end else begin
        res_lo = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        res_hi = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      zero_div <= 1'b0;
      opnd     <= '0;
      raw_a    <= '0;
      acc      <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            is_div   <= bus.op_sel[1];
            sign_q   <= in_signed & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            sign_r   <= in_signed & bus.op_sel[1] & bus.src_a[WIDTH-1];
            zero_div <= bus.op_sel[1] & (bus.src_b == '0);
            raw_a    <= bus.src_a;
            opnd     <= bus.op_sel[1] ? abs_b : abs_a;
            acc      <= {{WIDTH{1'b0}}, (bus.op_sel[1] ? abs_a : abs_b)};
            cnt      <= '0;
            busy_r   <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          if (bus.flush) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          busy_r <= 1'b0;
          state  <= IDLE;
          if (!bus.flush) begin
            hi_r   <= res_hi;
            lo_r   <= res_lo;
            dbz_r  <= zero_div;
            done_r <= 1'b1;
          end
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.div_by_zero = dbz_r;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_muldiv_unit : vector table plus corner sequences for muldiv_unit
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start for exactly one edge; afterwards the operand lines carry junk.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.op_sel = op;
    bus.src_a  = a;
    bus.src_b  = b;
    tick();
    bus.start  = 1'b0;
    bus.op_sel = 2'($urandom);
    bus.src_a  = $urandom;
    bus.src_b  = $urandom;
  endtask

  task automatic wait_done(input int start_lat, output int lat, output bit busy_ok);
    lat     = start_lat;
    busy_ok = 1'b1;
    while (!bus.done && lat < 60) begin
      if (!bus.busy) busy_ok = 1'b0;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    bit busy_ok;
    bit seen;
    total = 0;
    bad   = 0;

    vecs[0]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0};
    vecs[5]  = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{2'b10, 32'h0000000A, 32'h00000003, 32'h00000001, 32'h00000003, 1'b0};
    vecs[7]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{2'b10, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[11] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.op_sel = 2'b00;
    bus.src_a  = '0;
    bus.src_b  = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    chk("reset_dbz", 64'(bus.div_by_zero), 64'd0);

    // Each launch happens in the cycle done is high, so starts are back-to-back.
    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(0, lat, busy_ok);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(LAT));
      chk($sformatf("v%0d_busy_window", i), 64'(busy_ok), 64'd1);
      chk($sformatf("v%0d_busy_at_done", i), 64'(bus.busy), 64'd0);
      chk($sformatf("v%0d_hi", i), 64'(bus.hi), 64'(vecs[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(bus.lo), 64'(vecs[i].lo));
      chk($sformatf("v%0d_dbz", i), 64'(bus.div_by_zero), 64'(vecs[i].dbz));
    end

    // Start while busy is ignored.
    launch(2'b00, 32'd5, 32'd6);
    repeat (4) tick();
    bus.start  = 1'b1;
    bus.op_sel = 2'b10;
    bus.src_a  = 32'd100;
    bus.src_b  = 32'd7;
    tick();
    bus.start  = 1'b0;
    wait_done(5, lat, busy_ok);
    chk("ign_latency", 64'(lat), 64'(LAT));
    chk("ign_hi", 64'(bus.hi), 64'd0);
    chk("ign_lo", 64'(bus.lo), 64'd30);
    tick();
    chk("done_one_cycle", 64'(bus.done), 64'd0);
    chk("idle_after_done", 64'(bus.busy), 64'd0);

    // Flush mid-operation: no done, result registers untouched.
    launch(2'b10, 32'd100, 32'd7);
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done || bus.busy) seen = 1'b1;
      tick();
    end
    chk("flush_no_done", 64'(seen), 64'd0);
    chk("flush_hi", 64'(bus.hi), 64'd0);
    chk("flush_lo", 64'(bus.lo), 64'd30);

    // Start accompanied by flush in idle is dropped.
    bus.start = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_start_dropped", 64'(bus.busy), 64'd0);

    // Reset in the middle of a divu discards everything.
    launch(2'b11, 32'd1000, 32'd3);
    repeat (14) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_hi", 64'(bus.hi), 64'd0);
    chk("midrst_lo", 64'(bus.lo), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (bus.done || bus.busy) seen = 1'b1;
      tick();
    end
    chk("midrst_quiet", 64'(seen), 64'd0);

    launch(2'b01, 32'd7, 32'd8);
    wait_done(0, lat, busy_ok);
    chk("post_rst_latency", 64'(lat), 64'(LAT));
    chk("post_rst_hi", 64'(bus.hi), 64'd0);
    chk("post_rst_lo", 64'(bus.lo), 64'd56);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
